sram_rmw_ctrl: RTL and testbench
================================

Name: sram_rmw_ctrl

Overview:
- Upstream stage for the 2048x32 single-port SRAM wrapper.
- Converts a PULPino-style req/gnt/rvalid data-memory port with byte enables into the SRAM's word-only WRITEn/ADDR/WDATA interface.
- The SRAM has no byte-write capability, so partial writes are done as an internal read-modify-write (RMW) sequence.
- Gates every access launch on the SRAM READY output.

Parameters:
- ADDR_WIDTH, 11, SRAM word-address width (2048 words).
- DATA_WIDTH, 32, data word width; the only supported value is 32 (4 byte lanes).

Ports:
- clk  input  1  single clock; also drives the SRAM wrapper clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- req_i  input  1  bus request
- gnt_o  output  1  grant; the request is accepted in any cycle where req_i and gnt_o are both high
- addr_i  input  ADDR_WIDTH+2  byte address; bits [1:0] ignored
- we_i  input  1  1 = write, 0 = read
- be_i  input  4  byte enables, bit n selects byte lane n
- wdata_i  input  32  write data
- rvalid_o  output  1  response valid, one cycle per accepted request
- rdata_o  output  32  read data, meaningful only when rvalid_o=1 and the request was a read
- sram_writen_o  output  1  SRAM WRITEn; 0 = write, 1 = read/idle
- sram_addr_o  output  ADDR_WIDTH  SRAM word address
- sram_wdata_o  output  32  SRAM write data
- sram_rdata_i  input  32  SRAM RDATA; valid in the cycle after a read is launched
- sram_ready_i  input  1  SRAM READY; no access may launch while it is low

Behaviour:
- Chip select is tied active, so the SRAM accesses every cycle. sram_writen_o=1 in every cycle that does not launch a write; a read at that address is harmless.
- Reset values: FSM=IDLE, gnt_o=0 (gated by rst_n), rvalid_o=0, sram_writen_o=1, sram_addr_o=0, sram_wdata_o=0, rdata_o=0, internal merge/address/be registers cleared.
- FSM states: IDLE, RESP, RMW_MERGE, RMW_WRITE.
- Accept rule: gnt_o = rst_n & req_i & sram_ready_i & (state==IDLE | state==RESP). gnt_o is combinational.
- On accept, the access launches in the same cycle, with sram_addr_o = addr_i[ADDR_WIDTH+1:2]:
  - Read: sram_writen_o=1; next state RESP.
  - Write with be_i=1111: sram_writen_o=0, sram_wdata_o=wdata_i; next state RESP.
  - Write with be_i=0000: no SRAM write; next state RESP. This is a no-op write.
  - Write with partial be_i: sram_writen_o=1 (reads the old word); register addr, be, wdata; next state RMW_MERGE.
- RESP:
  - rvalid_o=1.
  - rdata_o = sram_rdata_i for reads, 0 for writes.
  - A new accept may happen in this same cycle, giving back-to-back throughput of 1 request/cycle for reads and full writes.
  - With no accept, next state IDLE.
- RMW_MERGE:
  - merge_q[8n+7:8n] = be_q[n] ? wdata_q[8n+7:8n] : sram_rdata_i[8n+7:8n].
  - sram_writen_o=1 and sram_addr_o=addr_q; no new access.
  - gnt_o=0; next state RMW_WRITE.
- RMW_WRITE:
  - If sram_ready_i: sram_writen_o=0, sram_addr_o=addr_q, sram_wdata_o=merge_q; next state RESP.
  - Otherwise stall with writen=1, holding merge_q. gnt_o=0 throughout.
- Latency from the accept cycle T:
  - Read, full write and no-op write: rvalid_o at T+1.
  - Partial write: SRAM write at T+2 (or later if READY is low), rvalid_o one cycle after the write.
- Hazards: because gnt_o is low during RMW, a later read to the same word always observes the merged data. A read issued the cycle after a full write returns the new data.
- Address wrap: addresses beyond 2^ADDR_WIDTH words alias; upper byte-address bits are ignored.
- sram_ready_i low in IDLE/RESP: no grant; the requester holds req_i. The RESP response (rvalid_o) is still produced.
- Reset mid-operation: immediately return to IDLE. No pending write may be issued (sram_writen_o=1 throughout), and no rvalid_o is produced for the aborted request.

Test Plan:
- Read: mem[4]=0xDEADBEEF; req_i=1, we_i=0, addr_i=0x010 -> gnt_o at T, sram_addr_o=4, writen=1; rvalid_o=1 and rdata_o=0xDEADBEEF at T+1.
- Full write then read: write 0x12345678, be=1111 to addr 0x020 at T; read of 0x020 at T+1 -> grants at T and T+1, writen=0 at T only, read rvalid at T+2 with 0x12345678.
- Partial write: mem[8]=0x11223344; write addr 0x020, be=0101, wdata=0xAABBCCDD -> gnt_o low T+1..T+2, writen=0 with wdata 0x11BB33DD at T+2, rvalid_o at T+3; a following read returns 0x11BB33DD.
- READY stall: hold sram_ready_i=0 -> gnt_o=0 with req_i high. In RMW_WRITE, ready low for 3 cycles -> the write launches in the first ready-high cycle and rvalid_o follows one cycle later.
- No-op write: we_i=1, be=0000 -> gnt_o at T, writen stays 1, rvalid_o at T+1, memory unchanged.
- Reset mid-RMW: assert rst_n=0 at T+1 of a partial write -> sram_writen_o=1, rvalid_o=0; after release the word is unchanged and a new request is granted normally.

Source files
------------

// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl: req/gnt/rvalid data-memory port to a word-only single-port SRAM.
// Byte-masked writes become an internal read-modify-write. Every launch waits
// for SRAM READY.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_i, gnt_o     request / combinational grant (accept when both high)
//   addr_i           byte address, bits [1:0] ignored
//   we_i, be_i       write enable, byte enables
//   wdata_i          write data
//   rvalid_o         one-cycle response per accepted request
//   rdata_o          read data (0 for write responses)
//   sram_writen_o    SRAM WRITEn (0 = write)
//   sram_addr_o      SRAM word address
//   sram_wdata_o     SRAM write data
//   sram_rdata_i     SRAM read data, valid the cycle after a read launch
//   sram_ready_i     SRAM READY, gates every launch
module sram_rmw_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH+1:0]     addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      sram_writen_o,
    output logic [ADDR_WIDTH-1:0]     sram_addr_o,
    output logic [DATA_WIDTH-1:0]     sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     sram_rdata_i,
    input  logic                      sram_ready_i
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle,
        StResp,
        StRmwMerge,
        StRmwWrite
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NumBytes-1:0]     be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
    logic                    resp_wr_q, resp_wr_d;

    // Word addressing drops the byte offset.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        merge_d       = merge_q;
        resp_wr_d     = resp_wr_q;
        sram_writen_o = 1'b1;
        sram_addr_o   = addr_q;
        sram_wdata_o  = '0;
        rvalid_o      = 1'b0;
        rdata_o       = '0;

        // rst_n in the grant keeps the port quiet while reset is held.
        gnt_o = rst_n & req_i & sram_ready_i &
                ((state_q == StIdle) | (state_q == StResp));

        case (state_q)
            StResp: begin
                rvalid_o = 1'b1;
                if (!resp_wr_q) begin
                    rdata_o = sram_rdata_i;
                end
                state_d = StIdle;
            end
            StRmwMerge: begin
                // Old word arrives this cycle from the read launched at accept.
                for (int n = 0; n < NumBytes; n++) begin
                    merge_d[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : sram_rdata_i[8*n +: 8];
                end
                state_d = StRmwWrite;
            end
            StRmwWrite: begin
                if (sram_ready_i) begin
                    sram_writen_o = 1'b0;
                    sram_wdata_o  = merge_q;
                    state_d       = StResp;
                end
            end
            default: ;
        endcase

        // Grant is only possible in IDLE/RESP, so it never overlaps an RMW write.
        if (gnt_o) begin
            sram_addr_o = addr_i[ADDR_WIDTH+1:2];
            addr_d      = addr_i[ADDR_WIDTH+1:2];
            resp_wr_d   = we_i;
            state_d     = StResp;
            if (we_i) begin
                if (be_i == '1) begin
                    sram_writen_o = 1'b0;
                    sram_wdata_o  = wdata_i;
                end else if (be_i != '0) begin
                    // Partial write: this cycle's access reads the old word.
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    state_d = StRmwMerge;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            resp_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            resp_wr_q <= resp_wr_d;
        end
    end

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
module tb_sram_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        gnt;
    logic [12:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        sram_writen;
    logic [10:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_rmw_ctrl #(
        .ADDR_WIDTH(11),
        .DATA_WIDTH(32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .sram_writen_o(sram_writen),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata),
        .sram_ready_i (sram_ready)
    );

    // Behavioural SRAM: write on WRITEn=0, registered read every cycle.
    logic [31:0] mem [2048];
    always @(posedge clk) begin
        if (!sram_writen) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h want %h", nm, k, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat;     // accept -> rvalid cycles
        int          wr_at;   // cycle of SRAM write, -1 none
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[11];

    task automatic run_txn(input vec_t v, input int idx);
        int waited = 0;
        @(posedge clk); #1;
        req = 1'b1; we = v.we; addr = v.addr; be = v.be; wdata = v.wd;
        @(negedge clk);
        while (!gnt && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk($sformatf("v%0d_gnt", idx), 0, {31'd0, gnt}, 32'd1);
        if (!gnt) begin
            req = 1'b0;
            return;
        end
        chk($sformatf("v%0d_addr", idx), 0, {21'd0, sram_addr}, {21'd0, v.addr[12:2]});
        for (int k = 0; k <= v.lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                req = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("v%0d_writen", idx), k, {31'd0, sram_writen},
                (k == v.wr_at) ? 32'd0 : 32'd1);
            if (k == v.wr_at) chk($sformatf("v%0d_wdata", idx), k, sram_wdata, v.exp_wd);
            chk($sformatf("v%0d_rvalid", idx), k, {31'd0, rvalid},
                (k == v.lat) ? 32'd1 : 32'd0);
            if (k == v.lat) chk($sformatf("v%0d_rdata", idx), k, rdata, v.exp_rd);
        end
    endtask

    task automatic issue(input logic w, input logic [12:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;

        //            we    addr     be    wdata          lat wr  exp_wd         exp_rd
        vecs[0]  = '{1'b0, 13'h010, 4'h0, 32'h0,         1, -1, 32'h0,         32'hDEADBEEF};
        vecs[1]  = '{1'b1, 13'h020, 4'h5, 32'hAABBCCDD,  3,  2, 32'h11BB33DD,  32'h0};
        vecs[2]  = '{1'b0, 13'h020, 4'h0, 32'h0,         1, -1, 32'h0,         32'h11BB33DD};
        vecs[3]  = '{1'b1, 13'h010, 4'h0, 32'h99999999,  1, -1, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 13'h010, 4'h0, 32'h0,         1, -1, 32'h0,         32'hDEADBEEF};
        vecs[5]  = '{1'b1, 13'h030, 4'hF, 32'hCAFEF00D,  1,  0, 32'hCAFEF00D,  32'h0};
        vecs[6]  = '{1'b0, 13'h030, 4'h0, 32'h0,         1, -1, 32'h0,         32'hCAFEF00D};
        vecs[7]  = '{1'b1, 13'h030, 4'h8, 32'h55000000,  3,  2, 32'h55FEF00D,  32'h0};
        vecs[8]  = '{1'b0, 13'h033, 4'h0, 32'h0,         1, -1, 32'h0,         32'h55FEF00D};
        vecs[9]  = '{1'b1, 13'h013, 4'h3, 32'h12349999,  3,  2, 32'hDEAD9999,  32'h0};
        vecs[10] = '{1'b0, 13'h010, 4'h0, 32'h0,         1, -1, 32'h0,         32'hDEAD9999};

        // Reset state, with req held high to see that grant is gated.
        rst_n = 1'b0; sram_ready = 1'b1;
        issue(1'b1, 13'h010, 4'hF, 32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        chk("rst_gnt", 0, {31'd0, gnt}, 32'd0);
        chk("rst_rvalid", 0, {31'd0, rvalid}, 32'd0);
        chk("rst_writen", 0, {31'd0, sram_writen}, 32'd1);
        chk("rst_addr", 0, {21'd0, sram_addr}, 32'd0);
        chk("rst_wdata", 0, sram_wdata, 32'd0);
        chk("rst_rdata", 0, rdata, 32'd0);
        @(posedge clk); #1;
        req = 1'b0; rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_txn(vecs[i], i);

        // Full write followed immediately by a read of the same word.
        @(posedge clk); #1;
        issue(1'b1, 13'h020, 4'hF, 32'h12345678);
        @(negedge clk);
        chk("b2b_gnt0", 0, {31'd0, gnt}, 32'd1);
        chk("b2b_writen0", 0, {31'd0, sram_writen}, 32'd0);
        @(posedge clk); #1;
        issue(1'b0, 13'h020, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b_gnt1", 1, {31'd0, gnt}, 32'd1);
        chk("b2b_writen1", 1, {31'd0, sram_writen}, 32'd1);
        chk("b2b_rvalid1", 1, {31'd0, rvalid}, 32'd1);
        chk("b2b_rdata1", 1, rdata, 32'd0);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid2", 2, {31'd0, rvalid}, 32'd1);
        chk("b2b_rdata2", 2, rdata, 32'h12345678);

        // READY low in IDLE blocks the grant; READY low in RESP still responds.
        @(posedge clk); #1;
        sram_ready = 1'b0;
        issue(1'b0, 13'h010, 4'h0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rdy_idle_gnt", k, {31'd0, gnt}, 32'd0);
            @(posedge clk); #1;
        end
        sram_ready = 1'b1;
        @(negedge clk);
        chk("rdy_idle_gnt_up", 2, {31'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        chk("rdy_resp_rvalid", 3, {31'd0, rvalid}, 32'd1);
        chk("rdy_resp_rdata", 3, rdata, 32'hDEAD9999);
        chk("rdy_resp_gnt", 3, {31'd0, gnt}, 32'd0);
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        chk("rdy_regnt", 4, {31'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("rdy_regnt_rvalid", 5, {31'd0, rvalid}, 32'd1);
        chk("rdy_regnt_rdata", 5, rdata, 32'hDEAD9999);

        // Partial write with READY low for 3 cycles in RMW_WRITE, and a read of
        // the same word pending the whole time.
        @(posedge clk); #1;
        issue(1'b1, 13'h040, 4'h1, 32'h000000AB);
        @(negedge clk);
        chk("stall_gnt0", 0, {31'd0, gnt}, 32'd1);
        chk("stall_writen0", 0, {31'd0, sram_writen}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            issue(1'b0, 13'h040, 4'h0, 32'h0);
            sram_ready = (k == 1);
            @(negedge clk);
            chk("stall_gnt", k, {31'd0, gnt}, 32'd0);
            chk("stall_writen", k, {31'd0, sram_writen}, 32'd1);
            chk("stall_rvalid", k, {31'd0, rvalid}, 32'd0);
        end
        @(posedge clk); #1;
        sram_ready = 1'b1;
        @(negedge clk);
        chk("stall_gnt5", 5, {31'd0, gnt}, 32'd0);
        chk("stall_writen5", 5, {31'd0, sram_writen}, 32'd0);
        chk("stall_wdata5", 5, sram_wdata, 32'h000000AB);
        chk("stall_rvalid5", 5, {31'd0, rvalid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_rvalid6", 6, {31'd0, rvalid}, 32'd1);
        chk("stall_rdata6", 6, rdata, 32'd0);
        chk("stall_gnt6", 6, {31'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("stall_rvalid7", 7, {31'd0, rvalid}, 32'd1);
        chk("stall_rdata7", 7, rdata, 32'h000000AB);

        // Reset during RMW: no write, no response, word unchanged.
        @(posedge clk); #1;
        issue(1'b1, 13'h020, 4'h1, 32'h000000FF);
        @(negedge clk);
        chk("rstrmw_gnt", 0, {31'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("rstrmw_writen", k, {31'd0, sram_writen}, 32'd1);
            chk("rstrmw_rvalid", k, {31'd0, rvalid}, 32'd0);
            @(posedge clk); #1;
            if (k == 2) rst_n = 1'b1;
        end
        run_txn('{1'b0, 13'h020, 4'h0, 32'h0, 1, -1, 32'h0, 32'h12345678}, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
